// File: rtl/insn_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
//   fetch_state_e : FETCH (nothing to discard) / FLUSH (drop stale responses)
//   fetch_entry_t : one buffered instruction, {pc, insn}
package insn_fetch_pkg;
  localparam int XLEN   = 64;
  localparam int INSN_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC   = 64'h0;
  localparam int              DEFAULT_FIFO_DEPTH = 2;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, insn} entries between memory responses and decode.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : empties the FIFO; a same-cycle push is discarded
//   push/entry  : write one entry
//   pop         : consume the head
//   head        : current head entry (valid when !empty)
//   count       : number of held entries; empty/full derived from it
// Push and pop in the same cycle both take effect, including when full:
// the head is read before the edge, so overwriting its slot is safe.
module fetch_fifo
  import insn_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage is not reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) mem[wr_ptr] <= push_entry;
  end
endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch: issues sequential 4-byte reads, buffers returned words
// with their PC, and handles redirects by flushing the buffer and dropping
// responses that were already in flight.
//   clk, reset                      : clock, synchronous active-high reset
//   redirect_valid/redirect_pc      : jump / taken branch target
//   mem_req_valid/ready/addr        : read request channel
//   mem_rsp_valid/data              : in-order read data, >= 1 cycle latency
//   insn_valid/ready, insn, insn_pc : head of buffer toward decode
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INSN_W-1:0] mem_rsp_data,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn,
  output logic [XLEN-1:0]   insn_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(2 * FIFO_DEPTH) + 1;

  fetch_state_e     state;
  logic [XLEN-1:0]  pc, rsp_pc, redirect_al;
  logic [OW-1:0]    outstanding, drop_cnt, drop_next, live;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty, fifo_full;
  logic             req_fire, rsp_drop, push, pop;
  fetch_entry_t     head;

  // Credit: buffered + live in-flight words may never exceed the FIFO, so a
  // kept response always has a slot. Dropped responses only need the total cap.
  assign live          = outstanding - drop_cnt;
  assign mem_req_valid = !reset && !redirect_valid
                       && (({1'b0, live} + (OW+1)'(fifo_count)) < (OW+1)'(FIFO_DEPTH))
                       && (outstanding < OW'(2 * FIFO_DEPTH));
  assign mem_req_addr  = pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign rsp_drop    = (state == FLUSH);
  assign push        = mem_rsp_valid && !rsp_drop && !redirect_valid;
  assign pop         = insn_valid && insn_ready;
  assign redirect_al = {redirect_pc[XLEN-1:2], 2'b00};

  // A redirect re-arms the drop count from everything still in flight,
  // excluding a response arriving this very cycle (it is discarded now).
  always_comb begin
    drop_next = drop_cnt;
    if (redirect_valid)
      drop_next = outstanding - OW'(mem_rsp_valid);
    else if (mem_rsp_valid && rsp_drop)
      drop_next = drop_cnt - 1'b1;
  end

  // rsp_pc tracks the address of the next kept response; dropped responses
  // never advance it, so no per-request address queue is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      state       <= FETCH;
    end else begin
      outstanding <= outstanding + OW'(req_fire) - OW'(mem_rsp_valid);
      drop_cnt    <= drop_next;
      state       <= (drop_next != '0) ? FLUSH : FETCH;
      if (redirect_valid) begin
        pc     <= redirect_al;
        rsp_pc <= redirect_al;
      end else begin
        if (req_fire) pc     <= pc + XLEN'(4);
        if (push)     rsp_pc <= rsp_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry ('{pc: rsp_pc, insn: mem_rsp_data}),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign insn_valid = !fifo_empty;
  assign insn       = head.insn;
  assign insn_pc    = head.pc;

  a_no_rsp_into_full: assert property (@(posedge clk) disable iff (reset)
    (mem_rsp_valid && state == FETCH) |-> !fifo_full);
  a_no_rsp_unrequested: assert property (@(posedge clk) disable iff (reset)
    mem_rsp_valid |-> (outstanding != '0));
endmodule

// File: doc/insn_fetch.md
INSN_FETCH -- requirements
Module: insn_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL set the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set the instruction buffer depth (power of two, at least 2).
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 redirect_valid  input  1  SHALL request a jump or taken branch to redirect_pc.
REQ-006 redirect_pc  input  64  SHALL carry the new fetch address.
REQ-007 mem_req_valid  output  1  SHALL indicate that an instruction read request is pending.
REQ-008 mem_req_ready  input  1  SHALL indicate that memory accepts the request.
REQ-009 mem_req_addr  output  64  SHALL carry the request byte address.
REQ-010 mem_rsp_valid  input  1  SHALL indicate that read data returned; data returns in order, at most one per cycle, no earlier than 1 cycle after acceptance.
REQ-011 mem_rsp_data  input  32  SHALL carry the instruction word.
REQ-012 insn_valid  output  1  SHALL indicate that the buffer head holds an instruction for decode and imm_gen.
REQ-013 insn_ready  input  1  SHALL indicate that decode consumes the head.
REQ-014 insn  output  32  SHALL carry the head instruction word.
REQ-015 insn_pc  output  64  SHALL carry the address of the head instruction.

Function
REQ-016 The request fires when mem_req_valid and mem_req_ready are both 1; mem_req_addr SHALL equal the fetch PC, and the PC SHALL advance by 4 on each fire.
REQ-017 mem_req_valid SHALL be 1 only when fifo_count + live_outstanding < FIFO_DEPTH, total outstanding < 2*FIFO_DEPTH, and redirect_valid is 0; live_outstanding = outstanding - drop_cnt.
REQ-018 Once asserted, mem_req_valid SHALL hold the address stable until it fires; the only permitted withdrawal is in a redirect cycle.
REQ-019 A non-dropped response SHALL push {PC, data} into the FIFO, and it SHALL appear at the outputs on the next cycle; there is no bypass.
REQ-020 insn_valid SHALL equal FIFO non-empty; the head SHALL pop when insn_valid and insn_ready are both 1.
REQ-021 A push and a pop in the same cycle SHALL both occur, including when the FIFO is full.
REQ-022 The credit rule SHALL make a response arriving while the FIFO is full impossible; an assertion SHALL flag it.
REQ-023 On redirect_valid the block SHALL take these actions:
  - flush the FIFO, including any same-cycle push;
  - set PC to {redirect_pc[63:2], 2'b00};
  - set drop_cnt to outstanding minus the same-cycle response fire.
REQ-024 The FSM SHALL have two states:
  - FETCH: drop_cnt = 0;
  - FLUSH: drop_cnt > 0; each response fire decrements drop_cnt and is discarded; the FSM returns to FETCH when drop_cnt reaches 0.
  - New requests are allowed in both states.
REQ-025 A head popped in the same cycle as a redirect SHALL count as consumed; the next insn_valid SHALL come only from the redirect stream.
REQ-026 Back-to-back redirects SHALL each reload the PC; drop_cnt SHALL recompute from the current outstanding count.
REQ-027 PC arithmetic SHALL be 64-bit modulo; 64'hFFFF_FFFF_FFFF_FFFC + 4 SHALL wrap to 0.

Reset
REQ-028 While reset is high, the block SHALL hold:
  - PC = RESET_PC;
  - FIFO empty;
  - outstanding = 0 and drop_cnt = 0;
  - state = FETCH;
  - mem_req_valid = 0 and insn_valid = 0.
REQ-029 mem_req_valid SHALL first assert in the cycle after reset deasserts.
REQ-030 Reset mid-operation SHALL abandon in-flight requests; memory shares the same reset and returns no stale responses.

Structure
REQ-031 The shared package SHALL hold the FSM state enum, the default RESET_PC, the default FIFO_DEPTH, and INSN_W = 32 and XLEN = 64.
REQ-032 One sub-module, fetch_fifo, SHALL be used: a synchronous FIFO of {pc, insn} entries with count output and flush input.

Verification
REQ-033 Reset with RESET_PC = 64'h1000, then hold ready=1, rsp latency 1, insn_ready=1 -> addresses 1000, 1004, 1008 issue and insn_pc follows in order, with the first insn_valid 2 cycles after the first fire.
REQ-034 Hold insn_ready = 0 -> exactly 2 requests accepted, FIFO full, mem_req_valid = 0; raise insn_ready -> fetch resumes with no loss or duplicate.
REQ-035 Redirect to 64'h2002 with 2 requests outstanding -> both responses dropped, next request address 64'h2000, first insn_pc 64'h2000.
REQ-036 Redirect in the same cycle as a response and a pop -> the response is discarded, drop_cnt = remaining outstanding, no stale instruction reaches the outputs.
REQ-037 Set PC to 64'hFFFF_FFFF_FFFF_FFFC -> the next address is 64'h0.
REQ-038 Assert reset with 2 requests outstanding and the FIFO full -> the next cycle shows all outputs at reset values, then fetch restarts at RESET_PC.
